fdiv_issue_ctrl: RTL and testbench

- Shares one multi-cycle FP32 divider (start/done interface, result plus zero_division/Overflow/Underflow flags) between N_REQ reservation-station requesters in the OoO core.
- Round-robin grants one request, sequences the divider, captures the result and broadcasts it with its ROB tag on the CDB using a valid/ready handshake.
- Handles pipeline flush while a division is in flight.

---
 rtl/fdiv_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/fdiv_issue_ctrl.sv | 173 +++++++++++++++++
 tb/tb_fdiv_issue_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdiv_pkg.sv
// Shared types and constants for the FP32 divider issue controller.
package fdiv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    OUT   = 3'd3,
    DRAIN = 3'd4
  } state_e;

  // Bit positions inside the 3-bit flag bundle {zero_division, overflow, underflow}
  localparam int FLAG_ZDIV = 2;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_UNF  = 0;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // FP32 field widths
  localparam int FP32_W     = 32;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first valid request at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic             en,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] gnt_idx
);

  // Scan upward from rr_ptr with wrap; the first valid request wins
  always_comb begin
    int                idx_i;
    logic [IDX_W-1:0]  idx_l;
    logic              found;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx_i   = 0;
    idx_l   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_i = int'(rr_ptr) + k;
      if (idx_i >= N_REQ) idx_i = idx_i - N_REQ;
      idx_l = IDX_W'(idx_i);
      if (en && !found && req[idx_l]) begin
        found        = 1'b1;
        grant[idx_l] = 1'b1;
        gnt_idx      = idx_l;
      end
    end
  end

endmodule

// File: rtl/fdiv_issue_ctrl.sv
// Shares one multi-cycle FP32 divider between N_REQ reservation-station
// requesters and broadcasts each quotient with its ROB tag on the CDB.
// Optional build macro FDIV_ZERO_BYPASS_EN: divisions by +/-0 skip the
// divider and produce the IEEE result directly.
module fdiv_issue_ctrl
  import fdiv_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int TAG_W = 6,
  parameter int W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*W-1:0]     req_a,
  input  logic [N_REQ*W-1:0]     req_b,
  input  logic [N_REQ*TAG_W-1:0] req_tag,
  output logic                   div_start,
  output logic [W-1:0]           div_a,
  output logic [W-1:0]           div_b,
  input  logic                   div_done,
  input  logic [W-1:0]           div_result,
  input  logic                   div_zero_division,
  input  logic                   div_overflow,
  input  logic                   div_underflow,
  output logic                   cdb_valid,
  input  logic                   cdb_ready,
  output logic [TAG_W-1:0]       cdb_tag,
  output logic [W-1:0]           cdb_result,
  output logic [2:0]             cdb_flags,
  input  logic                   flush,
  output logic                   busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state, state_nxt;
  logic [IDX_W-1:0] rr_ptr, gnt_idx;
  logic [N_REQ-1:0] grant;
  logic             arb_en, xfer, load_res, bypass;
  logic [W-1:0]     sel_a, sel_b;
  logic [TAG_W-1:0] sel_tag;
  logic [W-1:0]     op_a, op_b;
  logic [TAG_W-1:0] op_tag;
  logic [W-1:0]     res_r;
  logic [2:0]       flg_r, div_flags;
  logic [TAG_W-1:0] tag_r;

`ifdef FDIV_ZERO_BYPASS_EN
  // IEEE result of x/0: signed infinity with zero_division, or QNaN for 0/0
  function automatic logic [FP32_W+2:0] zero_bypass(input logic [FP32_W-1:0] a,
                                                    input logic [FP32_W-1:0] b);
    logic [2:0] f;
    f = '0;
    if (a[FP32_W-2:0] != '0) begin
      f[FLAG_ZDIV] = 1'b1;
      return {f, a[FP32_W-1] ^ b[FP32_W-1], {FP32_EXP_W{1'b1}}, {FP32_MAN_W{1'b0}}};
    end
    return {f, QNAN};
  endfunction

  assign bypass = xfer && (sel_b[FP32_W-2:0] == '0);
`else
  assign bypass = 1'b0;
`endif

  // Grants are only offered while idle and not being flushed or reset
  assign arb_en = (state == IDLE) && !flush && !rst;
  assign xfer   = |grant;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .en      (arb_en),
    .grant   (grant),
    .gnt_idx (gnt_idx)
  );

  // Select the granted requester's operands and tag
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_tag = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_a   = req_a[i*W +: W];
        sel_b   = req_b[i*W +: W];
        sel_tag = req_tag[i*TAG_W +: TAG_W];
      end
    end
  end

  // Pack divider status flags into the CDB flag layout
  always_comb begin
    div_flags            = '0;
    div_flags[FLAG_ZDIV] = div_zero_division;
    div_flags[FLAG_OVF]  = div_overflow;
    div_flags[FLAG_UNF]  = div_underflow;
  end

  // State register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (xfer) rr_ptr <= (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Next-state logic; a flush during ISSUE/WAIT must still drain the divider
  always_comb begin
    state_nxt = state;
    load_res  = 1'b0;
    case (state)
      IDLE:  if (xfer) state_nxt = bypass ? OUT : ISSUE;
      ISSUE: state_nxt = flush ? DRAIN : WAIT;
      WAIT: begin
        if (flush) begin
          state_nxt = div_done ? IDLE : DRAIN;
        end else if (div_done) begin
          state_nxt = OUT;
          load_res  = 1'b1;
        end
      end
      OUT:   if (flush || cdb_ready) state_nxt = IDLE;
      DRAIN: if (div_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on grant and result capture on divider completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      op_tag <= '0;
      res_r  <= '0;
      flg_r  <= '0;
      tag_r  <= '0;
    end else begin
      if (xfer) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        op_tag <= sel_tag;
      end
`ifdef FDIV_ZERO_BYPASS_EN
      if (bypass) begin
        {flg_r, res_r} <= zero_bypass(sel_a, sel_b);
        tag_r          <= sel_tag;
      end
`endif
      if (load_res) begin
        res_r <= div_result;
        flg_r <= div_flags;
        tag_r <= op_tag;
      end
    end
  end

  assign req_ready  = grant;
  assign div_start  = (state == ISSUE);
  assign div_a      = op_a;
  assign div_b      = op_b;
  assign cdb_valid  = (state == OUT);
  assign cdb_tag    = tag_r;
  assign cdb_result = res_r;
  assign cdb_flags  = flg_r;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Scoreboard bench for fdiv_issue_ctrl with a fixed-latency divider model.
module tb_fdiv_issue_ctrl;

  localparam int N_REQ   = 4;
  localparam int TAG_W   = 6;
  localparam int W       = 32;
  localparam int DIV_LAT = 12;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [N_REQ-1:0]       req_valid, req_ready;
  logic [N_REQ*W-1:0]     req_a, req_b;
  logic [N_REQ*TAG_W-1:0] req_tag;
  logic                   div_start;
  logic [W-1:0]           div_a, div_b;
  logic                   div_done;
  logic [W-1:0]           div_result;
  logic                   div_zero_division, div_overflow, div_underflow;
  logic                   cdb_valid, cdb_ready;
  logic [TAG_W-1:0]       cdb_tag;
  logic [W-1:0]           cdb_result;
  logic [2:0]             cdb_flags;
  logic                   flush, busy;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [W-1:0]     res;
    logic [2:0]       flg;
  } exp_t;

  exp_t         sb_q[$];
  logic [W+2:0] mq[$];     // divider model answers, {flags, result}
  int checks = 0, passes = 0, starts = 0, done_cnt = 0;

  fdiv_issue_ctrl #(.N_REQ(N_REQ), .TAG_W(TAG_W), .W(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .div_start(div_start), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_result(div_result),
    .div_zero_division(div_zero_division), .div_overflow(div_overflow),
    .div_underflow(div_underflow),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
    .cdb_result(cdb_result), .cdb_flags(cdb_flags),
    .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TAG_W-1:0] tag);
    req_a[i*W +: W]             = a;
    req_b[i*W +: W]             = b;
    req_tag[i*TAG_W +: TAG_W]   = tag;
    req_valid[i]                = 1'b1;
  endtask

  task automatic push_exp(input logic [TAG_W-1:0] tag, input logic [W-1:0] res,
                          input logic [2:0] flg);
    exp_t e;
    e.tag = tag; e.res = res; e.flg = flg;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for requester i to be granted, then withdraws its request
  task automatic wait_grant(input int i, input string nm);
    int c;
    c = 0;
    do begin @(negedge clk); c++; end
    while (!(req_ready[i] && req_valid[i]) && c < 200);
    chk(nm, req_ready[i], 1'b1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
  endtask

  // Waits (bounded) until all expected results were seen and the block is idle
  task automatic wait_idle(input string nm);
    int c;
    c = 0;
    do begin @(negedge clk); c++; end
    while ((sb_q.size() != 0 || busy) && c < 300);
    chk(nm, sb_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Divider model: fixed latency, answers popped from mq on each start
  initial begin
    int dcnt;
    logic [W+2:0] cur;
    dcnt = 0;
    cur  = '0;
    div_done = 1'b0; div_result = '0;
    div_zero_division = 1'b0; div_overflow = 1'b0; div_underflow = 1'b0;
    forever begin
      @(posedge clk); #1;
      div_done = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          div_done = 1'b1;
          {div_zero_division, div_overflow, div_underflow, div_result} = cur;
          done_cnt++;
        end
      end
      if (div_start) begin
        starts++;
        dcnt = DIV_LAT;
        cur  = (mq.size() > 0) ? mq.pop_front() : '0;
      end
    end
  end

  // Monitor: every CDB handshake must match the oldest expected result
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && cdb_valid && cdb_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL cdb_unexpected: tag 0x%0h result 0x%0h appeared with nothing pending",
                   cdb_tag, cdb_result);
        end else begin
          e = sb_q.pop_front();
          chk("cdb_tag", cdb_tag, e.tag);
          chk("cdb_result", cdb_result, e.res);
          chk("cdb_flags", cdb_flags, e.flg);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ca[4];
    int          ord[5];
    logic [3:0]  g;
    int          n, c, gi, s0, d0;
    logic [TAG_W-1:0] st_tag;
    logic [W-1:0]     st_res;
    logic [2:0]       st_flg;
    logic             ok, bad;

    req_valid = '0; req_a = '0; req_b = '0; req_tag = '0;
    cdb_ready = 1'b1; flush = 1'b0; rst = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 4'b0000);
    chk("rst_div_start", div_start, 1'b0);
    chk("rst_cdb_valid", cdb_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_div_a", div_a, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention: all four requesters held valid -> grants 0,1,2,3,0
    ca  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    ord = '{0, 1, 2, 3, 0};
    for (int k = 0; k < 4; k++) set_req(k, ca[k], 32'h3F800000, TAG_W'(20 + k));
    mq.push_back({3'b000, 32'h3F800000});
    mq.push_back({3'b010, 32'h40000000});
    mq.push_back({3'b001, 32'h40400000});
    mq.push_back({3'b000, 32'h40800000});
    mq.push_back({3'b000, 32'h3F800000});
    push_exp(6'd20, 32'h3F800000, 3'b000);
    push_exp(6'd21, 32'h40000000, 3'b010);
    push_exp(6'd22, 32'h40400000, 3'b001);
    push_exp(6'd23, 32'h40800000, 3'b000);
    push_exp(6'd20, 32'h3F800000, 3'b000);
    n = 0; c = 0;
    while (n < 5 && c < 400) begin
      @(negedge clk); c++;
      g = req_ready & req_valid;
      if (g != 4'b0000) begin
        gi = -1;
        for (int k = 0; k < 4; k++) if (g[k]) gi = k;
        chk("ct_onehot", $onehot(g), 1'b1);
        chk("ct_order", gi, ord[n]);
        chk("ct_idle_at_grant", busy, 1'b0);
        n++;
        if (n == 5) begin @(posedge clk); #1; req_valid = '0; end
      end
    end
    chk("ct_grant_count", n, 5);
    wait_idle("ct_drain");

    // Single request on requester 0
    s0 = starts;
    set_req(0, 32'h41200000, 32'h40000000, 6'd5);
    mq.push_back({3'b000, 32'h40A00000});
    push_exp(6'd5, 32'h40A00000, 3'b000);
    @(negedge clk);
    chk("sg_grant", req_ready, 4'b0001);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(negedge clk);
    chk("sg_start", div_start, 1'b1);
    chk("sg_div_a", div_a, 32'h41200000);
    chk("sg_div_b", div_b, 32'h40000000);
    chk("sg_busy", busy, 1'b1);
    @(negedge clk);
    chk("sg_start_one_cycle", div_start, 1'b0);
    wait_idle("sg_drain");
    chk("sg_start_count", starts - s0, 1);

    // Backpressure: CDB stalls, outputs must hold and no grant is offered
    cdb_ready = 1'b0;
    set_req(2, 32'h40400000, 32'h40400000, 6'd7);
    mq.push_back({3'b010, 32'h3F800000});
    push_exp(6'd7, 32'h3F800000, 3'b010);
    wait_grant(2, "bp_grant2");
    set_req(1, 32'h40C00000, 32'h40000000, 6'd8);
    mq.push_back({3'b000, 32'h40400000});
    push_exp(6'd8, 32'h40400000, 3'b000);
    c = 0;
    do begin @(negedge clk); c++; end while (!cdb_valid && c < 50);
    chk("bp_cdb_valid_seen", cdb_valid, 1'b1);
    st_tag = cdb_tag; st_res = cdb_result; st_flg = cdb_flags;
    repeat (5) begin
      @(negedge clk);
      ok = cdb_valid && (cdb_tag == st_tag) && (cdb_result == st_res) && (cdb_flags == st_flg);
      chk("bp_hold", ok, 1'b1);
      chk("bp_no_grant", req_ready, 4'b0000);
    end
    @(posedge clk); #1;
    cdb_ready = 1'b1;
    @(negedge clk);
    chk("bp_no_grant_on_handshake", req_ready, 4'b0000);
    @(negedge clk);
    chk("bp_next_grant", req_ready, 4'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_idle("bp_drain");

    // Flush three cycles after start: result of that division is dropped
    set_req(3, 32'h41000000, 32'h40000000, 6'd9);
    mq.push_back({3'b111, 32'hDEADBEEF});
    wait_grant(3, "fl_grant3");
    @(negedge clk);
    chk("fl_start", div_start, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    set_req(0, 32'h40C00000, 32'h40000000, 6'd11);
    mq.push_back({3'b000, 32'h40400000});
    push_exp(6'd11, 32'h40400000, 3'b000);
    @(posedge clk); #1;
    flush = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("fl_drain_busy", busy, 1'b1);
    chk("fl_drain_no_grant", req_ready, 4'b0000);
    wait_grant(0, "fl_grant_after_drain");
    chk("fl_done_before_grant", done_cnt > d0, 1'b1);
    wait_idle("fl_drain_idle");

    // Flush while holding a result on the CDB
    cdb_ready = 1'b0;
    set_req(1, 32'h40800000, 32'h40000000, 6'd14);
    mq.push_back({3'b000, 32'h40000000});
    wait_grant(1, "fo_grant1");
    c = 0;
    do begin @(negedge clk); c++; end while (!cdb_valid && c < 50);
    chk("fo_cdb_valid_seen", cdb_valid, 1'b1);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("fo_cdb_valid_dropped", cdb_valid, 1'b0);
    chk("fo_idle", busy, 1'b0);
    cdb_ready = 1'b1;
    wait_idle("fo_drain");

    // Zero divisor
    s0 = starts;
    set_req(1, 32'h40A00000, 32'h00000000, 6'd12);
    push_exp(6'd12, 32'h7F800000, 3'b100);
`ifdef FDIV_ZERO_BYPASS_EN
    wait_grant(1, "zb_grant");
    c = 0;
    while (!cdb_valid && c < 2) begin @(negedge clk); c++; end
    chk("zb_cdb_valid", cdb_valid, 1'b1);
    chk("zb_no_start", starts - s0, 0);
    wait_idle("zb_drain");
    chk("zb_still_no_start", starts - s0, 0);
`else
    mq.push_back({3'b100, 32'h7F800000});
    wait_grant(1, "zd_grant");
    wait_idle("zd_drain");
    chk("zd_start_issued", starts - s0, 1);
`endif

    // Reset in WAIT: outputs clear at once, the late div_done is ignored
    set_req(2, 32'h40000000, 32'h3F800000, 6'd13);
    mq.push_back({3'b000, 32'h12345678});
    wait_grant(2, "rs_grant2");
    repeat (3) @(posedge clk);
    #1;
    d0 = done_cnt;
    rst = 1'b1;
    #1;
    chk("rs_busy", busy, 1'b0);
    chk("rs_div_start", div_start, 1'b0);
    chk("rs_div_a", div_a, 32'h0);
    chk("rs_div_b", div_b, 32'h0);
    chk("rs_cdb_valid", cdb_valid, 1'b0);
    chk("rs_cdb_tag", cdb_tag, 6'd0);
    chk("rs_req_ready", req_ready, 4'b0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (cdb_valid || busy) bad = 1'b1;
    end
    chk("rs_stray_done_seen", done_cnt > d0, 1'b1);
    chk("rs_stray_done_ignored", bad, 1'b0);

    chk("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
